// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared widths, state and op encodings for the exponentiation sequencer
package mont_pkg;

  localparam int DEF_DATA_W = 512;
  localparam int DEF_EXP_W  = 512;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    NEXT  = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CONV_IN  = 2'd0,
    SQR      = 2'd1,
    MUL      = 2'd2,
    CONV_OUT = 2'd3
  } op_e;

endpackage

// File: rtl/montgomery_exp_ctrl.sv
// rtl/montgomery_exp_ctrl.sv - square-and-multiply sequencer driving a Montgomery multiplier
module montgomery_exp_ctrl
  import mont_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int EXP_W  = DEF_EXP_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] in_x,
  input  logic [EXP_W-1:0]  in_e,
  input  logic [DATA_W-1:0] in_m,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_r2,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              mul_start,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  output logic [DATA_W-1:0] mul_m,
  input  logic [DATA_W-1:0] mul_result,
  input  logic              mul_done
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [EXP_W-1:0]   e_q;
  logic [DATA_W-1:0]  m_q;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  xt_q;
  logic [DATA_W-1:0]  result_q;
  logic [DATA_W-1:0]  mul_a_q, mul_b_q;
  logic [DATA_W-1:0]  opa_d, opb_d;
  logic               mul_start_q, done_q;
  logic               accept;
  logic               capture;

  assign accept  = (state_q == IDLE) && start;
  assign capture = (state_q == WAIT) && mul_done;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          op_d    = CONV_IN;
          idx_d   = IDX_W'(EXP_W - 1);
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mul_done) state_d = NEXT;
      end
      NEXT: begin
        state_d = ISSUE;
        unique case (op_q)
          CONV_IN: op_d = SQR;
          SQR, MUL: begin
            if (op_q == SQR && e_q[idx_q]) begin
              op_d = MUL;
            end else if (idx_q == '0) begin
              op_d = CONV_OUT;
            end else begin
              op_d  = SQR;
              idx_d = idx_q - 1'b1;
            end
          end
          CONV_OUT: state_d = DONE;
        endcase
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // CONV_IN is only ever entered from IDLE, so its operands come straight off the
  // inputs; mul_a_q/mul_b_q then hold the latched x and R2 for the whole product.
  always_comb begin
    opa_d = a_q;
    opb_d = a_q;
    unique case (op_d)
      CONV_IN: begin
        opa_d = in_x;
        opb_d = in_r2;
      end
      SQR:      opb_d = a_q;
      MUL:      opb_d = xt_q;
      CONV_OUT: opb_d = DATA_W'(1);
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      op_q        <= CONV_IN;
      idx_q       <= '0;
      e_q         <= '0;
      m_q         <= '0;
      a_q         <= '0;
      xt_q        <= '0;
      result_q    <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      mul_start_q <= (state_d == ISSUE);
      done_q      <= (state_d == DONE);
      if (accept) begin
        e_q <= in_e;
        m_q <= in_m;
        a_q <= in_r;
      end
      if (state_d == ISSUE) begin
        mul_a_q <= opa_d;
        mul_b_q <= opb_d;
      end
      if (capture) begin
        unique case (op_q)
          CONV_IN:  xt_q     <= mul_result;
          SQR, MUL: a_q      <= mul_result;
          CONV_OUT: result_q <= mul_result;
        endcase
      end
    end
  end

  assign result    = result_q;
  assign done      = done_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_m     = m_q;

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// tb/tb_montgomery_exp_ctrl.sv - randomized self-checking bench with a behavioural Montgomery multiplier
module tb_montgomery_exp_ctrl;

  localparam int DATA_W = 512;
  localparam int EXP_W  = 8;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] in_x = '0, in_m = '0, in_r = '0, in_r2 = '0;
  logic [EXP_W-1:0]  in_e = '0;
  logic [DATA_W-1:0] result, mul_a, mul_b, mul_m;
  logic [DATA_W-1:0] mul_result = '0;
  logic              done, mul_start;
  logic              mul_done = 1'b0;

  always #5 clk = ~clk;

  montgomery_exp_ctrl #(.DATA_W(DATA_W), .EXP_W(EXP_W)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
    .result(result), .done(done),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
    .mul_result(mul_result), .mul_done(mul_done)
  );

  int total = 0;
  int bad = 0;

  longint mod_m, r_m, r2_m, rinv_m;
  int     lat = 1;
  bit     tie = 1'b0;
  int     cyc = 0;
  int     done_cnt = 0;
  longint qa[$], qb[$], qm[$];
  int     qc[$];
  longint ea[$], eb[$];

  function automatic longint mm(longint a, longint b);
    return (((a * b) % mod_m) * rinv_m) % mod_m;
  endfunction

  // Behavioural multiplier: result a*b*R^-1 mod M, mul_done in the lat-th cycle after mul_start.
  int     busy = 0;
  int     cnt = 0;
  longint rq = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!resetn) begin
      busy     <= 0;
      mul_done <= 1'b0;
    end else begin
      mul_done <= tie;
      if (mul_start) begin
        rq <= mm(longint'(mul_a[63:0]), longint'(mul_b[63:0]));
        if (lat == 1) begin
          mul_done   <= 1'b1;
          mul_result <= DATA_W'(mm(longint'(mul_a[63:0]), longint'(mul_b[63:0])));
        end else begin
          busy <= 1;
          cnt  <= lat - 1;
        end
      end else if (busy != 0) begin
        if (cnt == 1) begin
          mul_done   <= 1'b1;
          mul_result <= DATA_W'(rq);
          busy       <= 0;
        end
        cnt <= cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mul_start) begin
      qa.push_back(longint'(mul_a[63:0]));
      qb.push_back(longint'(mul_b[63:0]));
      qm.push_back(longint'(mul_m[63:0]));
      qc.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  task automatic setup(input longint m);
    longint r;
    mod_m = m;
    r = 1;
    repeat (DATA_W) r = (r * 2) % m;
    r_m  = r;
    r2_m = (r * r) % m;
    rinv_m = 0;
    for (longint k = 1; k < m; k++) if ((r * k) % m == 1) rinv_m = k;
  endtask

  function automatic longint ref_pow(input longint x, input int e);
    longint p = 1 % mod_m;
    for (int k = 0; k < e; k++) p = (p * x) % mod_m;
    return p;
  endfunction

  // Expected operand pairs, tracking A in the ordinary domain and mapping into Montgomery form.
  task automatic build_exp(input longint x, input logic [EXP_W-1:0] e);
    longint an, xt;
    ea.delete(); eb.delete();
    ea.push_back(x); eb.push_back(r2_m);
    xt = (x * r_m) % mod_m;
    an = 1 % mod_m;
    for (int i = EXP_W - 1; i >= 0; i--) begin
      ea.push_back((an * r_m) % mod_m); eb.push_back((an * r_m) % mod_m);
      an = (an * an) % mod_m;
      if (e[i]) begin
        ea.push_back((an * r_m) % mod_m); eb.push_back(xt);
        an = (an * x) % mod_m;
      end
    end
    ea.push_back((an * r_m) % mod_m); eb.push_back(1);
  endtask

  task automatic run_chain(input longint x, input logic [EXP_W-1:0] e, input int l,
                           input bit t, input bit restart, output bit ok);
    lat = l;
    tie = t;
    @(negedge clk);
    qa.delete(); qb.delete(); qm.delete(); qc.delete();
    done_cnt = 0;
    in_x  = DATA_W'(x);
    in_e  = e;
    in_m  = DATA_W'(mod_m);
    in_r  = DATA_W'(r_m);
    in_r2 = DATA_W'(r2_m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (restart && k == 15) begin
        start = 1'b1;
        in_x  = DATA_W'((x + 1) % mod_m);
        in_e  = ~e;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%0h want=0", result); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (mul_start !== 1'b0) begin bad++; $display("FAIL reset_mul_start got=%b want=0", mul_start); end
    total++; if (mul_a !== '0 || mul_b !== '0 || mul_m !== '0) begin
      bad++; $display("FAIL reset_operands got=%0h/%0h/%0h want=0/0/0", mul_a, mul_b, mul_m);
    end
  endtask

  task automatic test_basic;
    bit ok;
    setup(13);
    build_exp(5, 8'd3);
    run_chain(5, 8'd3, 1, 1'b0, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=no_done want=done"); end
    total++; if (result !== DATA_W'(8)) begin bad++; $display("FAIL basic_result got=%0d want=8", result); end
    total++; if (qc.size() != 12) begin bad++; $display("FAIL basic_starts got=%0d want=12", qc.size()); end
    total++;
    if (qa.size() != ea.size()) begin
      bad++; $display("FAIL basic_op_count got=%0d want=%0d", qa.size(), ea.size());
    end else begin
      for (int k = 0; k < qa.size(); k++) begin
        total++;
        if (qa[k] != ea[k] || qb[k] != eb[k] || qm[k] != mod_m) begin
          bad++; $display("FAIL basic_operands[%0d] got=%0d,%0d,%0d want=%0d,%0d,%0d",
                          k, qa[k], qb[k], qm[k], ea[k], eb[k], mod_m);
        end
      end
    end
    repeat (3) @(negedge clk);
    total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt); end
    total++; if (result !== DATA_W'(8)) begin bad++; $display("FAIL basic_result_held got=%0d want=8", result); end
  endtask

  task automatic test_e_zero_one;
    bit ok;
    setup(13);
    run_chain(5, 8'd0, 1, 1'b0, 1'b0, ok);
    total++; if (!ok || result !== DATA_W'(1)) begin bad++; $display("FAIL ezero_result got=%0d want=1", result); end
    total++; if (qc.size() != 10) begin bad++; $display("FAIL ezero_starts got=%0d want=10", qc.size()); end
    run_chain(12, 8'd1, 1, 1'b0, 1'b0, ok);
    total++; if (!ok || result !== DATA_W'(12)) begin bad++; $display("FAIL eone_result got=%0d want=12", result); end
    total++; if (qc.size() != 11) begin bad++; $display("FAIL eone_starts got=%0d want=11", qc.size()); end
  endtask

  task automatic test_all_ones_latency;
    bit ok;
    longint x;
    setup(1009);
    x = longint'($urandom_range(1, 1008));
    run_chain(x, 8'hFF, 5, 1'b0, 1'b0, ok);
    total++; if (!ok || result !== DATA_W'(ref_pow(x, 255))) begin
      bad++; $display("FAIL ones_result got=%0d want=%0d", result, ref_pow(x, 255));
    end
    total++; if (qc.size() != 18) begin bad++; $display("FAIL ones_starts got=%0d want=18", qc.size()); end
    for (int k = 1; k < qc.size(); k++) begin
      total++;
      if (qc[k] - qc[k-1] != 7) begin
        bad++; $display("FAIL ones_spacing[%0d] got=%0d want=7", k, qc[k] - qc[k-1]);
      end
    end
  endtask

  task automatic test_restart_ignored;
    bit ok;
    setup(13);
    run_chain(5, 8'hA5, 2, 1'b0, 1'b1, ok);
    total++; if (!ok || result !== DATA_W'(ref_pow(5, 8'hA5))) begin
      bad++; $display("FAIL restart_result got=%0d want=%0d", result, ref_pow(5, 8'hA5));
    end
    total++; if (qc.size() != 14) begin bad++; $display("FAIL restart_starts got=%0d want=14", qc.size()); end
  endtask

  task automatic test_reset_mid_chain;
    bit ok;
    int seen = 0;
    setup(97);
    lat = 3;
    tie = 1'b0;
    @(negedge clk);
    in_x = DATA_W'(11); in_e = 8'h6D; in_m = DATA_W'(mod_m);
    in_r = DATA_W'(r_m); in_r2 = DATA_W'(r2_m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200 && seen < 3; k++) begin
      if (mul_start) seen++;
      if (seen < 3) @(negedge clk);
    end
    total++; if (seen != 3) begin bad++; $display("FAIL midreset_reach got=%0d want=3", seen); end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    total++; if (result !== '0 || done !== 1'b0 || mul_start !== 1'b0 ||
                 mul_a !== '0 || mul_b !== '0 || mul_m !== '0) begin
      bad++; $display("FAIL midreset_outputs got=%0h/%b/%b/%0h/%0h/%0h want=all_zero",
                      result, done, mul_start, mul_a, mul_b, mul_m);
    end
    total++; if (dut.state_q !== mont_pkg::IDLE || dut.idx_q !== '0) begin
      bad++; $display("FAIL midreset_state got=%0d/%0d want=0/0", dut.state_q, dut.idx_q);
    end
    @(negedge clk);
    resetn = 1'b1;
    run_chain(11, 8'h6D, 3, 1'b0, 1'b0, ok);
    total++; if (!ok || result !== DATA_W'(ref_pow(11, 8'h6D))) begin
      bad++; $display("FAIL midreset_rerun got=%0d want=%0d", result, ref_pow(11, 8'h6D));
    end
  endtask

  task automatic test_tie_high;
    bit ok;
    longint x;
    setup(251);
    x = longint'($urandom_range(2, 250));
    build_exp(x, 8'hC3);
    run_chain(x, 8'hC3, 1, 1'b1, 1'b0, ok);
    total++; if (!ok || result !== DATA_W'(ref_pow(x, 8'hC3))) begin
      bad++; $display("FAIL tie_result got=%0d want=%0d", result, ref_pow(x, 8'hC3));
    end
    total++;
    if (qa.size() != ea.size()) begin
      bad++; $display("FAIL tie_op_count got=%0d want=%0d", qa.size(), ea.size());
    end else begin
      for (int k = 0; k < qa.size(); k++) begin
        total++;
        if (qa[k] != ea[k] || qb[k] != eb[k]) begin
          bad++; $display("FAIL tie_operands[%0d] got=%0d,%0d want=%0d,%0d", k, qa[k], qb[k], ea[k], eb[k]);
        end
        if (k > 0) begin
          total++;
          if (qc[k] - qc[k-1] != 3) begin
            bad++; $display("FAIL tie_spacing[%0d] got=%0d want=3", k, qc[k] - qc[k-1]);
          end
        end
      end
    end
    tie = 1'b0;
  endtask

  task automatic test_random;
    bit ok;
    longint m, x;
    logic [EXP_W-1:0] e;
    int l, pc;
    for (int it = 0; it < 6; it++) begin
      m = longint'($urandom_range(1, 2047)) * 2 + 1;
      setup(m);
      x = longint'($urandom_range(0, 32'(m - 1)));
      e = EXP_W'($urandom);
      l = $urandom_range(1, 4);
      pc = $countones(e);
      run_chain(x, e, l, 1'b0, 1'b0, ok);
      total++; if (!ok || result !== DATA_W'(ref_pow(x, int'(e)))) begin
        bad++; $display("FAIL rand_result[%0d] got=%0d want=%0d", it, result, ref_pow(x, int'(e)));
      end
      total++; if (qc.size() != 2 + EXP_W + pc) begin
        bad++; $display("FAIL rand_starts[%0d] got=%0d want=%0d", it, qc.size(), 2 + EXP_W + pc);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    resetn = 1'b1;
    @(negedge clk);
    test_reset;
    test_basic;
    test_e_zero_one;
    test_all_ones_latency;
    test_restart_ignored;
    test_reset_mid_chain;
    test_tie_high;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
